uart_rx: RTL and testbench

- Even-parity UART receiver. Directly downstream of uart_tx: its serial output drives RxD over the link.
- Frame format is identical to uart_tx: start (0), DATA_WIDTH data bits with MSB first on the line, even parity bit, one stop (1).
- Synchronises RxD, centres on each bit by mid-bit sampling, and delivers the received word with parity and framing status to the host logic.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_sync.sv | 24 ++
 rtl/uart_rx.sv | 181 ++++++++++++++++++
 tb/tb_uart_rx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, bit-timing and parity helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Whole clock cycles per line bit (integer division, remainder dropped).
  function automatic int cycles_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Even-parity bit for a word: 1 when the word holds an odd number of ones.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side bundle of the UART receiver: received word, status flags and acknowledge.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] RxData;
  logic                  rx_valid;
  logic                  parity_err;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;
  logic                  rx_ready;

  modport master (
    output RxData, rx_valid, parity_err, frame_err, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  RxData, rx_valid, parity_err, frame_err, overrun, busy,
    output rx_ready
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for a single asynchronous input; reset value selectable.
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Bring d into the clk domain through two back-to-back flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Even-parity UART receiver: start, DATA_WIDTH bits MSB first, even parity, one stop.
// Bits are sampled at their centres after a two-flop synchroniser.
// Optional UART_RX_OVERRUN_EN: words are held until rx_ready and overwrites set a
// sticky overrun flag; without it rx_valid is a single-cycle pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      RxD,
  uart_rx_if.master rx
);

  localparam int CPB      = cycles_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT = CPB / 2;
  localparam int CW       = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IW       = $clog2(DATA_WIDTH);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CPB - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [IW-1:0] IDX_TOP   = IW'(DATA_WIDTH - 1);

  logic                  rxd_s;
  logic                  rxd_prev;
  rx_state_t             state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [DATA_WIDTH-1:0] shift;
  logic                  perr;
  logic                  stop_done;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  parity_err_q;
  logic                  frame_err_q;
  logic                  busy_q;
  logic                  rx_valid_q;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (RxD),
    .q       (rxd_s)
  );

  // Completion of a frame: the stop-bit centre sample happens this cycle.
  assign stop_done = (state == STOP) && (cnt == CNT_LAST);

  // Frame FSM: edge-detect the start bit, then sample each bit at its centre.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_prev     <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      idx          <= '0;
      shift        <= '0;
      perr         <= 1'b0;
      rx_data_q    <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rxd_prev <= rxd_s;
      case (state)
        IDLE: begin
          busy_q <= 1'b0;
          if (rxd_prev && !rxd_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxd_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              state <= DATA;
              idx   <= IDX_TOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            shift[idx] <= rxd_s;
            if (idx == '0) begin
              state <= PARITY;
            end else begin
              idx <= idx - 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            perr  <= even_parity(64'(shift)) ^ rxd_s;
            state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt          <= '0;
            state        <= IDLE;
            busy_q       <= 1'b0;
            rx_data_q    <= shift;
            parity_err_q <= perr;
            frame_err_q  <= ~rxd_s;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_RX_OVERRUN_EN
  logic overrun_q;

  // Hold each word until the host acknowledges; an unread word being replaced
  // raises a sticky overrun that only an acknowledge clears.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      done_q <= stop_done;
      if (stop_done) begin
        if (rx_valid_q && !rx.rx_ready) begin
          overrun_q <= 1'b1;
        end else if (rx_valid_q && rx.rx_ready) begin
          overrun_q <= 1'b0;
        end
      end else if (rx_valid_q && rx.rx_ready) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end else if (done_q) begin
        rx_valid_q <= 1'b1;
      end
    end
  end

  assign rx.overrun = overrun_q;
`else
  // Announce each completed word with a single-cycle rx_valid pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
    end else begin
      done_q     <= stop_done;
      rx_valid_q <= done_q;
    end
  end

  assign rx.overrun = 1'b0;
`endif

  assign rx.RxData     = rx_data_q;
  assign rx.rx_valid   = rx_valid_q;
  assign rx.parity_err = parity_err_q;
  assign rx.frame_err  = frame_err_q;
  assign rx.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a 16-cycles-per-bit instance for the functional
// cases and a default-parameter instance (868 cycles per bit) for one frame.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int SMALL_CPB = 16;
  localparam int BIG_CPB   = 100_000_000 / 115_200;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic rxd = 1'b1;
  logic rxd_big = 1'b1;

  int checks = 0;
  int fails = 0;

  uart_rx_if #(.DATA_WIDTH(8)) rx_if ();
  uart_rx_if #(.DATA_WIDTH(8)) big_if ();

  uart_rx #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_WIDTH(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .RxD     (rxd),
    .rx      (rx_if.master)
  );

  uart_rx dut_big (
    .clk     (clk),
    .reset_n (reset_n),
    .RxD     (rxd_big),
    .rx      (big_if.master)
  );

  always #5 clk = ~clk;

  // Capture every rising edge of rx_valid together with the word and flags.
  int         valid_rises = 0;
  int         big_rises = 0;
  logic       valid_d = 1'b0;
  logic       big_d = 1'b0;
  logic [7:0] word_q[$];
  logic       last_perr = 1'b0;
  logic       last_ferr = 1'b0;
  logic [7:0] big_word = 8'h00;
  logic       big_perr = 1'b0;
  logic       big_ferr = 1'b0;
  logic       busy_ok;

  always @(negedge clk) begin
    if (rx_if.rx_valid && !valid_d) begin
      valid_rises++;
      word_q.push_back(rx_if.RxData);
      last_perr = rx_if.parity_err;
      last_ferr = rx_if.frame_err;
    end
    valid_d = rx_if.rx_valid;
    if (big_if.rx_valid && !big_d) begin
      big_rises++;
      big_word = big_if.RxData;
      big_perr = big_if.parity_err;
      big_ferr = big_if.frame_err;
    end
    big_d = big_if.rx_valid;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame MSB first from a negedge; on the small instance busy is
  // sampled at the centre of every bit.
  task automatic apply_stimulus(input logic [7:0] data, input logic par, input logic stop, input bit big);
    logic [10:0] frame;
    int          cpb;
    frame = {1'b0, data, par, stop};
    cpb = big ? BIG_CPB : SMALL_CPB;
    for (int i = 10; i >= 0; i--) begin
      if (big) rxd_big = frame[i];
      else rxd = frame[i];
      repeat (cpb / 2) @(negedge clk);
      if (!big && rx_if.busy !== 1'b1) busy_ok = 1'b0;
      repeat (cpb - cpb / 2) @(negedge clk);
    end
  endtask

  function automatic logic [7:0] last_word(input int back);
    return word_q[word_q.size() - 1 - back];
  endfunction

  int r0;

  initial begin
    rx_if.rx_ready = 1'b1;
    big_if.rx_ready = 1'b1;
    busy_ok = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check_output("reset_rxdata", 32'(rx_if.RxData), 32'h0);
    check_output("reset_valid", 32'(rx_if.rx_valid), 32'h0);
    check_output("reset_busy", 32'(rx_if.busy), 32'h0);
    check_output("reset_perr", 32'(rx_if.parity_err), 32'h0);
    check_output("reset_ferr", 32'(rx_if.frame_err), 32'h0);
    check_output("reset_overrun", 32'(rx_if.overrun), 32'h0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);

    // Clean frame 0xA5
    $display("[TB] clean frame");
    r0 = valid_rises;
    busy_ok = 1'b1;
    apply_stimulus(8'hA5, ^8'hA5, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("clean_rises", 32'(valid_rises), 32'(r0 + 1));
    check_output("clean_word", 32'(last_word(0)), 32'hA5);
    check_output("clean_perr", 32'(last_perr), 32'h0);
    check_output("clean_ferr", 32'(last_ferr), 32'h0);
    check_output("clean_busy_frame", 32'(busy_ok), 32'h1);
    check_output("clean_busy_after", 32'(rx_if.busy), 32'h0);
    check_output("pulse_valid_low", 32'(rx_if.rx_valid), 32'h0);

    // Parity error: 0x3C carries four ones, so parity 1 is wrong
    $display("[TB] parity error");
    r0 = valid_rises;
    apply_stimulus(8'h3C, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("par_rises", 32'(valid_rises), 32'(r0 + 1));
    check_output("par_word", 32'(last_word(0)), 32'h3C);
    check_output("par_perr", 32'(last_perr), 32'h1);
    check_output("par_ferr", 32'(last_ferr), 32'h0);

    // Framing error followed by a 40-cycle break
    $display("[TB] framing error and break");
    r0 = valid_rises;
    apply_stimulus(8'hFF, 1'b0, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_output("frm_rises", 32'(valid_rises), 32'(r0 + 1));
    check_output("frm_word", 32'(last_word(0)), 32'hFF);
    check_output("frm_ferr", 32'(last_ferr), 32'h1);
    check_output("frm_perr", 32'(last_perr), 32'h0);
    check_output("brk_busy", 32'(rx_if.busy), 32'h0);
    rxd = 1'b1;
    repeat (20) @(negedge clk);
    check_output("brk_no_valid", 32'(valid_rises), 32'(r0 + 1));
    apply_stimulus(8'hC3, ^8'hC3, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("brk_recover_rises", 32'(valid_rises), 32'(r0 + 2));
    check_output("brk_recover_word", 32'(last_word(0)), 32'hC3);
    check_output("brk_recover_ferr", 32'(last_ferr), 32'h0);

    // Glitch: 5 low cycles is a false start
    $display("[TB] glitch");
    r0 = valid_rises;
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    check_output("glitch_busy_high", 32'(rx_if.busy), 32'h1);
    rxd = 1'b1;
    repeat (7) @(negedge clk);
    check_output("glitch_busy_low", 32'(rx_if.busy), 32'h0);
    check_output("glitch_state", 32'(dut.state), 32'(IDLE));
    repeat (200) @(negedge clk);
    check_output("glitch_no_valid", 32'(valid_rises), 32'(r0));

    // Back-to-back frames with no idle gap
    $display("[TB] back to back");
    r0 = valid_rises;
    apply_stimulus(8'h01, ^8'h01, 1'b1, 1'b0);
    apply_stimulus(8'h80, ^8'h80, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("b2b_rises", 32'(valid_rises), 32'(r0 + 2));
    check_output("b2b_word0", 32'(last_word(1)), 32'h01);
    check_output("b2b_word1", 32'(last_word(0)), 32'h80);

    // Reset in the middle of the data bits of a third frame
    $display("[TB] reset mid frame");
    rxd = 1'b0;
    repeat (SMALL_CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * SMALL_CPB + 3) @(negedge clk);
    check_output("mid_busy", 32'(rx_if.busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_rxdata", 32'(rx_if.RxData), 32'h0);
    check_output("rst_valid", 32'(rx_if.rx_valid), 32'h0);
    check_output("rst_busy", 32'(rx_if.busy), 32'h0);
    check_output("rst_perr", 32'(rx_if.parity_err), 32'h0);
    check_output("rst_ferr", 32'(rx_if.frame_err), 32'h0);
    check_output("rst_overrun", 32'(rx_if.overrun), 32'h0);
    @(negedge clk);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    r0 = valid_rises;
    apply_stimulus(8'h55, ^8'h55, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("post_rst_rises", 32'(valid_rises), 32'(r0 + 1));
    check_output("post_rst_word", 32'(last_word(0)), 32'h55);
    check_output("post_rst_perr", 32'(last_perr), 32'h0);

    // Two frames with nobody reading
    $display("[TB] unread words");
    rx_if.rx_ready = 1'b0;
    r0 = valid_rises;
    apply_stimulus(8'h11, ^8'h11, 1'b1, 1'b0);
`ifdef UART_RX_OVERRUN_EN
    apply_stimulus(8'h22, ^8'h22, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check_output("ovr_rises", 32'(valid_rises), 32'(r0 + 1));
    check_output("ovr_valid", 32'(rx_if.rx_valid), 32'h1);
    check_output("ovr_word", 32'(rx_if.RxData), 32'h22);
    check_output("ovr_flag", 32'(rx_if.overrun), 32'h1);
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    check_output("ack_valid", 32'(rx_if.rx_valid), 32'h0);
    check_output("ack_overrun", 32'(rx_if.overrun), 32'h0);
`else
    repeat (4) @(negedge clk);
    check_output("noovr_rises", 32'(valid_rises), 32'(r0 + 1));
    check_output("noovr_word", 32'(rx_if.RxData), 32'h11);
    check_output("noovr_valid", 32'(rx_if.rx_valid), 32'h0);
    check_output("noovr_flag", 32'(rx_if.overrun), 32'h0);
`endif
    rx_if.rx_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Default parameters: 868 cycles per bit
    $display("[TB] default parameters");
    r0 = big_rises;
    apply_stimulus(8'h5A, ^8'h5A, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    check_output("big_rises", 32'(big_rises), 32'(r0 + 1));
    check_output("big_word", 32'(big_word), 32'h5A);
    check_output("big_perr", 32'(big_perr), 32'h0);
    check_output("big_ferr", 32'(big_ferr), 32'h0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
